// File: rtl/ctrl_bubble_stage.sv
// ctrl_bubble_stage
//
// ID/EX control-word pipeline register with hazard bubble injection.
// The decoded control word is registered and split into WB/MEM/EX fields.
// A hazard request writes a run of all-zero bubbles while hold_o tells the
// PC and IF/ID stages not to advance. Stall freezes the stage; flush kills
// its contents.
//
// Optional feature macro: HZD_BUBBLE_STATS_EN adds bubble_cnt_o, a saturating
// count of injected bubbles.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   control_i    decoded control word, layout {WB, MEM, EX}, MSB first
//   bubble_i     hazard unit requests bubble injection
//   bubble_len_i number of bubbles requested (0 treated as 1)
//   stall_i      freeze stage (downstream stall)
//   flush_i      kill current contents
//   control_WB   registered WB field
//   control_MEM  registered MEM field
//   control_EX   registered EX field
//   bubble_o     registered; current output word is a bubble
//   hold_o       combinational; PC and IF/ID must not advance this cycle
//   bubble_cnt_o (HZD_BUBBLE_STATS_EN only) saturating bubble count

module ctrl_bubble_stage #(
   parameter int unsigned WB_W  = 2,
   parameter int unsigned MEM_W = 2,
   parameter int unsigned EX_W  = 4,
   parameter int unsigned CNT_W = 2,
   localparam int unsigned CTRL_W = WB_W + MEM_W + EX_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] control_i,
   input  logic              bubble_i,
   input  logic [CNT_W-1:0]  bubble_len_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic [WB_W-1:0]   control_WB,
   output logic [MEM_W-1:0]  control_MEM,
   output logic [EX_W-1:0]   control_EX,
   output logic              bubble_o,
   output logic              hold_o
`ifdef HZD_BUBBLE_STATS_EN
   ,
   output logic [15:0]       bubble_cnt_o
`endif
);

   typedef enum logic [0:0] {StRun, StInject} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [CTRL_W-1:0]  word_q, word_d;
   logic               bubble_q, bubble_d;
   logic [CNT_W-1:0]   len_eff;
   logic               bubble_write;

   // A zero-length request still costs one bubble.
   assign len_eff = (bubble_len_i == '0) ? CNT_W'(1) : bubble_len_i;

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      word_d       = word_q;
      bubble_d     = bubble_q;
      bubble_write = 1'b0;

      if (flush_i) begin
         state_d  = StRun;
         rem_d    = '0;
         word_d   = '0;
         bubble_d = 1'b1;
      end else if (stall_i) begin
         // everything holds
      end else begin
         unique case (state_q)
            StRun: begin
               if (bubble_i) begin
                  word_d       = '0;
                  bubble_d     = 1'b1;
                  bubble_write = 1'b1;
                  if (len_eff != CNT_W'(1)) begin
                     state_d = StInject;
                     rem_d   = len_eff - CNT_W'(1);
                  end
               end else begin
                  word_d   = control_i;
                  bubble_d = 1'b0;
               end
            end
            StInject: begin
               word_d       = '0;
               bubble_d     = 1'b1;
               bubble_write = 1'b1;
               rem_d        = rem_q - CNT_W'(1);
               // rem_q of 0 is unreachable here; treat it as the last bubble anyway.
               if (rem_q <= CNT_W'(1)) begin
                  state_d = StRun;
                  rem_d   = '0;
               end
            end
            default: begin
               state_d = StRun;
               rem_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= StRun;
         rem_q    <= '0;
         word_q   <= '0;
         bubble_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         word_q   <= word_d;
         bubble_q <= bubble_d;
      end
   end

   // Independent of stall_i: the stall path gates upstream on its own.
   assign hold_o = !flush_i && (((state_q == StRun) && bubble_i) || (state_q == StInject));

   assign control_WB  = word_q[CTRL_W-1 -: WB_W];
   assign control_MEM = word_q[EX_W +: MEM_W];
   assign control_EX  = word_q[EX_W-1:0];
   assign bubble_o    = bubble_q;

`ifdef HZD_BUBBLE_STATS_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else if (bubble_write && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bubble_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
module tb_ctrl_bubble_stage;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] control_i;
   logic       bubble_i;
   logic [1:0] bubble_len_i;
   logic       stall_i;
   logic       flush_i;
   logic [1:0] control_WB;
   logic [1:0] control_MEM;
   logic [3:0] control_EX;
   logic       bubble_o;
   logic       hold_o;
`ifdef HZD_BUBBLE_STATS_EN
   logic [15:0] bubble_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   ctrl_bubble_stage #(
      .WB_W (2),
      .MEM_W(2),
      .EX_W (4),
      .CNT_W(2)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .control_i   (control_i),
      .bubble_i    (bubble_i),
      .bubble_len_i(bubble_len_i),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .control_WB  (control_WB),
      .control_MEM (control_MEM),
      .control_EX  (control_EX),
      .bubble_o    (bubble_o),
      .hold_o      (hold_o)
`ifdef HZD_BUBBLE_STATS_EN
      ,
      .bubble_cnt_o(bubble_cnt_o)
`endif
   );

   typedef struct {
      int         id;
      logic [7:0] word;
      logic       bub;
      logic       hold;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Expected values describe what the DUT shows during the cycle in which
   // the matching inputs are applied: registered outputs from the previous
   // edge, hold_o from the current inputs.
   task automatic step(input int id, input logic rst, input logic [7:0] ctrl,
                       input logic bub, input logic [1:0] len, input logic stall,
                       input logic flush, input logic [7:0] e_word, input logic e_bub,
                       input logic e_hold, input logic [15:0] e_cnt);
      exp_t e;
      rst_i        = rst;
      control_i    = ctrl;
      bubble_i     = bub;
      bubble_len_i = len;
      stall_i      = stall;
      flush_i      = flush;
      e.id   = id;
      e.word = e_word;
      e.bub  = e_bub;
      e.hold = e_hold;
      e.cnt  = e_cnt;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: outputs are presented every cycle; pop and compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({control_WB, control_MEM, control_EX} !== e.word || bubble_o !== e.bub ||
                hold_o !== e.hold) begin
               errors++;
               $display("FAIL step%0d: got word=%h bubble=%b hold=%b, want word=%h bubble=%b hold=%b",
                        e.id, {control_WB, control_MEM, control_EX}, bubble_o, hold_o,
                        e.word, e.bub, e.hold);
            end
`ifdef HZD_BUBBLE_STATS_EN
            checks++;
            if (bubble_cnt_o !== e.cnt) begin
               errors++;
               $display("FAIL step%0d_cnt: got %0d, want %0d", e.id, bubble_cnt_o, e.cnt);
            end
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d items pending", exp_q.size());
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      rst_i        = 1'b0;
      control_i    = 8'h00;
      bubble_i     = 1'b0;
      bubble_len_i = 2'd0;
      stall_i      = 1'b0;
      flush_i      = 1'b0;
      @(posedge clk_i);
      #1;
      // reset state
      e.id = 0; e.word = 8'h00; e.bub = 1'b1; e.hold = 1'b0; e.cnt = 16'd0;
      exp_q.push_back(e);
      @(posedge clk_i);
      #1;
      //   id rst ctrl  bub len stl fl   word   b  hold cnt
      step( 1, 1, 8'hA5, 0, 0, 0, 0, 8'h00, 1, 0,  0);  // release, capture A5
      step( 2, 1, 8'hFF, 1, 1, 0, 0, 8'hA5, 0, 1,  0);  // single bubble
      step( 3, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 1, 0,  1);
      step( 4, 1, 8'h11, 1, 3, 0, 0, 8'hFF, 0, 1,  1);  // run of 3
      step( 5, 1, 8'h11, 1, 3, 0, 0, 8'h00, 1, 1,  2);  // INJECT ignores bubble_i
      step( 6, 1, 8'h11, 1, 3, 0, 0, 8'h00, 1, 1,  3);
      step( 7, 1, 8'h11, 0, 0, 0, 0, 8'h00, 1, 0,  4);  // held word captured now
      step( 8, 1, 8'h22, 1, 3, 0, 0, 8'h11, 0, 1,  4);  // run of 3 with stall
      step( 9, 1, 8'h22, 0, 0, 1, 0, 8'h00, 1, 1,  5);
      step(10, 1, 8'h22, 0, 0, 1, 0, 8'h00, 1, 1,  5);
      step(11, 1, 8'h22, 0, 0, 0, 0, 8'h00, 1, 1,  5);
      step(12, 1, 8'h22, 0, 0, 0, 0, 8'h00, 1, 1,  6);
      step(13, 1, 8'h22, 0, 0, 0, 0, 8'h00, 1, 0,  7);
      step(14, 1, 8'h33, 1, 0, 0, 0, 8'h22, 0, 1,  7);  // len 0 acts as 1
      step(15, 1, 8'h33, 0, 0, 1, 0, 8'h00, 1, 0,  8);  // stall in RUN
      step(16, 1, 8'h33, 0, 0, 0, 0, 8'h00, 1, 0,  8);
      step(17, 1, 8'h44, 1, 2, 0, 0, 8'h33, 0, 1,  8);  // enter INJECT
      step(18, 1, 8'h44, 1, 2, 0, 1, 8'h00, 1, 0,  9);  // flush kills injection
      step(19, 1, 8'h3C, 0, 0, 0, 0, 8'h00, 1, 0,  9);
      step(20, 1, 8'h55, 1, 3, 1, 1, 8'h3C, 0, 0,  9);  // flush beats stall+bubble
      step(21, 1, 8'h55, 0, 0, 0, 0, 8'h00, 1, 0,  9);
      step(22, 1, 8'h66, 1, 3, 0, 0, 8'h55, 0, 1,  9);  // enter INJECT
      step(23, 0, 8'h77, 0, 0, 0, 0, 8'h00, 1, 0,  0);  // async reset mid-INJECT
      step(24, 1, 8'h77, 0, 0, 0, 0, 8'h00, 1, 0,  0);
      step(25, 1, 8'h00, 0, 0, 0, 0, 8'h77, 0, 0,  0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
